square_period_meter: RTL
========================

Name: square_period_meter

Overview:
- Downstream consumer of the rectified square wave produced by the rectifier stage.
- Measures the period and high time of that wave in clk cycles, and averages over 2^AVG_LOG2 consecutive periods.
- Publishes the results with a one-cycle valid strobe, and flags loss of signal on timeout.
- Feeds the frequency/duty calculation logic of the measurement path.

Parameters:
- CNT_W, 32, width of the period/high-time counters and outputs.
- AVG_LOG2, 2, log2 of the number of periods averaged per result (default 4 periods).
- TIMEOUT, 50_000_000, cycles without a rising edge before no_signal asserts (1 s at 50 MHz).
- GLITCH_LEN, 3, stability length in cycles; used only when GLITCH_FILT_EN is defined.

Ports:
- clk  input  1  50 MHz system clock.
- rst_n  input  1  asynchronous active-low reset.
- signal_rectified  input  1  square wave, synchronous to clk.
- period_out  output  CNT_W  averaged period in clk cycles.
- high_time_out  output  CNT_W  averaged high time in clk cycles.
- meas_valid  output  1  one-cycle pulse when period_out/high_time_out update.
- no_signal  output  1  level; high while no edges are present.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: period_out=0, high_time_out=0, meas_valid=0, no_signal=1, state=IDLE. All counters and accumulators are 0, and the edge-history register is 0.
- Edge detection:
  - sq_d holds signal_rectified delayed by one clk.
  - rise = sig & ~sq_d; fall = ~sig & sq_d, where sig is the (optionally filtered) input.
- Sample definitions:
  - Period sample = number of clk edges between two consecutive detected rises. Example: rises detected on clk N and N+100 give a sample of 100.
  - High sample = clk edges from a rise to the following fall.
- State machine:
  - IDLE: wait for a rise. On a rise: period_cnt<=1, high_cnt<=1, go to MEASURE. The rise that starts MEASURE produces no sample.
  - MEASURE:
    - period_cnt increments every cycle.
    - high_cnt increments while sig=1 and freezes at a fall.
    - On a rise: add period_cnt to acc_p and high_cnt to acc_h, increment samp_cnt, then reload period_cnt<=1 and high_cnt<=1.
    - When samp_cnt reaches 2^AVG_LOG2 on that rise:
      - period_out <= (acc_p + period_cnt) >> AVG_LOG2, and high_time_out likewise (truncating shift).
      - Pulse meas_valid on the next cycle (1-cycle latency after the completing rise is detected).
      - Clear the accumulators and samp_cnt.
      - no_signal <= 0 at the same edge as the meas_valid pulse.
    - Timeout: if period_cnt reaches TIMEOUT, go to IDLE, set no_signal<=1, and discard the partial accumulation. period_out and high_time_out hold their last values.
- Widths:
  - Accumulators are CNT_W+AVG_LOG2 bits, so there is no overflow.
  - period_cnt saturates at TIMEOUT and cannot wrap; TIMEOUT must be < 2^CNT_W.
- Boundary conditions:
  - meas_valid is never high for two consecutive cycles.
  - A constant-high input never produces a rise, so it times out the same as constant-low.
  - Reset mid-measurement returns immediately to the reset values. The first result after reset requires 2^AVG_LOG2+1 rises.
  - The minimum measurable period is 2 cycles.

Optional Feature:
- Macro: GLITCH_FILT_EN.
- When defined:
  - sig is a filtered copy of signal_rectified. sig changes only after the raw input has held the new level for GLITCH_LEN consecutive cycles.
  - Pulses or gaps shorter than GLITCH_LEN cycles are ignored.
  - The filter adds GLITCH_LEN cycles of fixed latency and leaves clean-signal periods and high times unchanged.
  - The filter register resets to 0.
- When undefined: sig = signal_rectified directly, with no added latency.

Test Plan:
- Clean square, period 100, high 40, AVG_LOG2=2 -> after the 5th rise, one meas_valid pulse with period_out=100, high_time_out=40, no_signal=0; repeats every 400 cycles.
- Periods 99, 101, 100, 104 (high fixed at 50) -> period_out=101 (404>>2), high_time_out=50.
- TIMEOUT=1000; run a valid square wave, then hold the input low for 1000 cycles -> no_signal=1 and outputs hold their last values. Resume a 100-cycle period -> valid again after 5 rises.
- Assert rst_n low during the 3rd period, then release -> all outputs at reset values. The first meas_valid arrives only after 5 new rises, with correct values.
- GLITCH_FILT_EN on, GLITCH_LEN=3: period-100 square with a 1-cycle high glitch at mid-low -> period_out stays 100. With the macro off, the same stimulus yields corrupted samples (for example 50).
- Minimum period 2 (alternating 1/0) -> period_out=2, high_time_out=1, meas_valid every 8 cycles.

Source files
------------

// File: rtl/square_period_meter.sv
// square_period_meter
// Measures the period and high time of a clk-synchronous square wave in clk
// cycles. Each result is the truncated mean of 2**AVG_LOG2 consecutive periods.
// Each new result is announced with a one-cycle meas_valid pulse. no_signal is
// raised when TIMEOUT cycles pass without a rising edge.
//
// Optional build macro GLITCH_FILT_EN adds an input glitch filter. With the
// filter, the input must hold a new level for GLITCH_LEN cycles before the
// meter sees it. Without the macro the raw input is used directly.
module square_period_meter #(
  parameter int CNT_W      = 32,
  parameter int AVG_LOG2   = 2,
  parameter int TIMEOUT    = 50_000_000,
  parameter int GLITCH_LEN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             signal_rectified,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_time_out,
  output logic             meas_valid,
  output logic             no_signal
);

  // Accumulators carry AVG_LOG2 extra bits so summing 2**AVG_LOG2 samples of
  // up to CNT_W bits each can never overflow.
  localparam int ACC_W  = CNT_W + AVG_LOG2;
  localparam int SAMP_W = AVG_LOG2 + 1;

  // Value of samp_cnt_q on the rise that completes an averaging window.
  localparam logic [SAMP_W-1:0] SAMP_LAST   = SAMP_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

  // FSM encoding
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

  // Configurations the counters cannot represent.
  // TIMEOUT must fit in CNT_W bits and leave room for a 2-cycle period.
  // GLITCH_LEN must be at least one cycle.
  // This block is empty: it only names the illegal corner so that it is
  // visible when reading the parameter list.
  if (TIMEOUT < 2 || GLITCH_LEN < 1 || AVG_LOG2 < 0) begin : g_bad_params
  end

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic sig;

`ifdef GLITCH_FILT_EN
  localparam int GCNT_W = $clog2(GLITCH_LEN + 1);
  localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GLITCH_LEN - 1);

  logic              sig_filt_q, sig_filt_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;

  // Count consecutive cycles where the raw input disagrees with the filtered
  // level. The filtered level follows only after GLITCH_LEN such cycles.
  always_comb begin
    sig_filt_d = sig_filt_q;
    gcnt_d     = '0;
    if (signal_rectified != sig_filt_q) begin
      if (gcnt_q == GCNT_LAST) begin
        sig_filt_d = signal_rectified;
        gcnt_d     = '0;
      end else begin
        gcnt_d = gcnt_q + 1'b1;
      end
    end
  end

  // Filter registers. Reset to a low level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_filt_q <= 1'b0;
      gcnt_q     <= '0;
    end else begin
      sig_filt_q <= sig_filt_d;
      gcnt_q     <= gcnt_d;
    end
  end

  assign sig = sig_filt_q;
`else
  assign sig = signal_rectified;
`endif

  // ---------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------
  logic sq_q, sq_d;
  logic rise;

  // sq holds sig from the previous cycle. A rise is a low-to-high step of sig.
  always_comb begin
    sq_d = sig;
    rise = sig & ~sq_q;
  end

  // ---------------------------------------------------------------------------
  // Measurement state
  // ---------------------------------------------------------------------------
  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;
  logic [ACC_W-1:0]  acc_p_q, acc_p_d;
  logic [ACC_W-1:0]  acc_h_q, acc_h_d;
  logic [SAMP_W-1:0] samp_cnt_q, samp_cnt_d;
  logic [CNT_W-1:0]  period_out_q, period_out_d;
  logic [CNT_W-1:0]  high_time_out_q, high_time_out_d;
  logic              meas_valid_q, meas_valid_d;
  logic              no_signal_q, no_signal_d;
  logic [ACC_W-1:0]  sum_p, sum_h;

  // Next-state logic.
  // A rise closes the running sample and folds it into the accumulators.
  // When the rise closes the last sample of a window, a result is published
  // instead. When period_cnt reaches TIMEOUT, the partial window is dropped.
  always_comb begin
    state_d         = state_q;
    period_cnt_d    = period_cnt_q;
    high_cnt_d      = high_cnt_q;
    acc_p_d         = acc_p_q;
    acc_h_d         = acc_h_q;
    samp_cnt_d      = samp_cnt_q;
    period_out_d    = period_out_q;
    high_time_out_d = high_time_out_q;
    meas_valid_d    = 1'b0;
    no_signal_d     = no_signal_q;

    // Running totals including the sample closed by a rise in this cycle.
    sum_p = acc_p_q + ACC_W'(period_cnt_q);
    sum_h = acc_h_q + ACC_W'(high_cnt_q);

    case (state_q)
      ST_IDLE: begin
        // The first rise only arms the counters; it yields no sample.
        if (rise) begin
          state_d      = ST_MEASURE;
          period_cnt_d = CNT_ONE;
          high_cnt_d   = CNT_ONE;
          acc_p_d      = '0;
          acc_h_d      = '0;
          samp_cnt_d   = '0;
        end
      end

      ST_MEASURE: begin
        if (period_cnt_q == TIMEOUT_CNT) begin
          // Lost signal: forget the partial window and keep the last result.
          // This also covers a rise landing in this same cycle.
          state_d      = ST_IDLE;
          no_signal_d  = 1'b1;
          period_cnt_d = '0;
          high_cnt_d   = '0;
          acc_p_d      = '0;
          acc_h_d      = '0;
          samp_cnt_d   = '0;
        end else if (rise) begin
          period_cnt_d = CNT_ONE;
          high_cnt_d   = CNT_ONE;
          if (samp_cnt_q == SAMP_LAST) begin
            period_out_d    = CNT_W'(sum_p >> AVG_LOG2);
            high_time_out_d = CNT_W'(sum_h >> AVG_LOG2);
            meas_valid_d    = 1'b1;
            no_signal_d     = 1'b0;
            acc_p_d         = '0;
            acc_h_d         = '0;
            samp_cnt_d      = '0;
          end else begin
            acc_p_d    = sum_p;
            acc_h_d    = sum_h;
            samp_cnt_d = samp_cnt_q + 1'b1;
          end
        end else begin
          // Below TIMEOUT here, so the increment cannot pass it.
          // The TIMEOUT branch above stops the count, so it saturates.
          period_cnt_d = period_cnt_q + 1'b1;
          // high_cnt runs only while the wave is high, so it freezes at the fall.
          if (sig) begin
            high_cnt_d = high_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_q            <= 1'b0;
      state_q         <= ST_IDLE;
      period_cnt_q    <= '0;
      high_cnt_q      <= '0;
      acc_p_q         <= '0;
      acc_h_q         <= '0;
      samp_cnt_q      <= '0;
      period_out_q    <= '0;
      high_time_out_q <= '0;
      meas_valid_q    <= 1'b0;
      no_signal_q     <= 1'b1;
    end else begin
      sq_q            <= sq_d;
      state_q         <= state_d;
      period_cnt_q    <= period_cnt_d;
      high_cnt_q      <= high_cnt_d;
      acc_p_q         <= acc_p_d;
      acc_h_q         <= acc_h_d;
      samp_cnt_q      <= samp_cnt_d;
      period_out_q    <= period_out_d;
      high_time_out_q <= high_time_out_d;
      meas_valid_q    <= meas_valid_d;
      no_signal_q     <= no_signal_d;
    end
  end

  // Outputs come directly from registers.
  assign period_out    = period_out_q;
  assign high_time_out = high_time_out_q;
  assign meas_valid    = meas_valid_q;
  assign no_signal     = no_signal_q;

endmodule
